spi_mnrch: RTL and testbench

- 16-bit full-duplex SPI master ("monarch") for the inertial sensor interface. Mode 3: SCLK idles high, MOSI changes on the SCLK fall, MISO is sampled on the SCLK rise, MSB first.
- One snd pulse runs one 16-bit frame with SS_n held low. The word shifted in from MISO is presented on resp, and done is asserted.
- Sits between the inertial-sensor command logic and the off-chip sensor pins.

---
 rtl/spi_mnrch_pkg.sv | 19 +
 rtl/spi_mnrch.sv | 111 +++++++++++
 tb/tb_spi_mnrch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mnrch_pkg.sv
// Shared constants and state encoding for the spi_mnrch SPI master.
package spi_mnrch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIV_W  = 5;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DivLoad = 5'b10111;
    localparam logic [DIV_W-1:0] DivRise = 5'b01111;
    localparam logic [DIV_W-1:0] DivFall = 5'b11111;

    typedef enum logic [1:0] {
        StIdle,
        StFront,
        StShift,
        StBack
    } state_e;

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit mode-3 SPI master; SCLK = divider MSB, MSB first, one frame per snd pulse.
// Optional busy output when SPI_MNRCH_BUSY_EN is defined.
module spi_mnrch
    import spi_mnrch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              snd,
    input  logic [DATA_W-1:0] cmd,
    input  logic              MISO,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    output logic              done,
`ifdef SPI_MNRCH_BUSY_EN
    output logic              busy,
`endif
    output logic [DATA_W-1:0] resp
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DATA_W-1:0]  shft_q, shft_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               smpl_q, smpl_d;
    logic               done_q, done_d;
    logic               ss_n_q, ss_n_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= DivLoad;
            shft_q  <= '0;
            cnt_q   <= '0;
            smpl_q  <= 1'b0;
            done_q  <= 1'b0;
            ss_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            shft_q  <= shft_d;
            cnt_q   <= cnt_d;
            smpl_q  <= smpl_d;
            done_q  <= done_d;
            ss_n_q  <= ss_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        shft_d  = shft_q;
        cnt_d   = cnt_q;
        smpl_d  = smpl_q;
        done_d  = done_q;
        ss_n_d  = ss_n_q;
        unique case (state_q)
            StIdle: begin
                // Divider rests at the load value; the accept edge is its first count.
                div_d = DivLoad;
                if (snd) begin
                    shft_d  = cmd;
                    div_d   = DivLoad + DIV_W'(1);
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    state_d = StFront;
                end
            end
            StFront: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DivFall) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == DivRise) begin
                    smpl_d = MISO;
                end
                if (div_q == DivFall) begin
                    shft_d = {shft_q[DATA_W-2:0], smpl_q};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        // Last shift ends the frame; holding the divider suppresses a trailing fall.
                        div_d   = DivLoad;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StBack;
                    end
                end
            end
            StBack: begin
                div_d   = DivLoad;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign SCLK = (state_q == StFront || state_q == StShift) ? div_q[DIV_W-1] : 1'b1;
    assign SS_n = ss_n_q;
    assign MOSI = shft_q[DATA_W-1];
    assign done = done_q;
    assign resp = shft_q;

`ifdef SPI_MNRCH_BUSY_EN
    assign busy = ~ss_n_q;
`endif

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch with a small iNEMO-style slave model and a loopback mode.
module tb_spi_mnrch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd = 1'b0;
    logic [15:0] cmd = '0;
    logic        miso;
    logic        SS_n, SCLK, MOSI, done;
    logic [15:0] resp;
`ifdef SPI_MNRCH_BUSY_EN
    logic        busy;
`endif

    logic        loop_en = 1'b0;
    logic        miso_m  = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    int f_len, f_rises, f_sp_bad, f_idle_bad, f_gap, f_busy_bad;
    logic f_ss_start, f_ss_end, f_sclk_end;

    always #5 clk = ~clk;

    assign miso = loop_en ? MOSI : miso_m;

    spi_mnrch u_dut (
        .clk  (clk),
        .rst  (rst),
        .snd  (snd),
        .cmd  (cmd),
        .MISO (miso),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .done (done),
`ifdef SPI_MNRCH_BUSY_EN
        .busy (busy),
`endif
        .resp (resp)
    );

    // Slave model: captures MOSI on SCLK rise, drives MISO on SCLK fall.
    int          rises   = 0;
    logic [15:0] s_in    = '0;
    logic [7:0]  rd_data = '0;
    logic        int_q   = 1'b0;
    logic [2:0]  idx;

    always @(posedge SCLK or posedge SS_n) begin
        if (SS_n) begin
            if (rises == 16 && !s_in[15] && s_in[14:8] == 7'h0D) begin
                int_q = s_in[1];
            end
            rises = 0;
        end else begin
            s_in  = {s_in[14:0], MOSI};
            rises = rises + 1;
            if (rises == 8) begin
                rd_data = (s_in[7] && s_in[6:0] == 7'h0F) ? 8'h6A : 8'h00;
            end
        end
    end

    always @(negedge SCLK) begin
        if (!SS_n) begin
            idx    = 3'(15 - rises);
            miso_m = (rises >= 8 && rises < 16) ? rd_data[idx] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; cycle 0 is the sample just after the accept edge.
    task automatic run_frame(input logic [15:0] c, input bit retrig);
        int   cyc;
        int   last;
        logic prev;
        @(negedge clk);
        cmd = c;
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        cmd = 16'h1234;
        f_ss_start = SS_n;
        cyc  = 0;
        last = -1;
        prev = SCLK;
        f_rises = 0; f_sp_bad = 0; f_idle_bad = 0; f_busy_bad = 0;
`ifdef SPI_MNRCH_BUSY_EN
        if (busy !== 1'b1) f_busy_bad++;
`endif
        while (done !== 1'b1 && cyc < 1000) begin
            if (retrig && cyc == 100) begin
                cmd = 16'hFFFF;
                snd = 1'b1;
            end else begin
                snd = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (prev == 1'b0 && SCLK == 1'b1 && SS_n == 1'b0) begin
                if (last >= 0 && cyc - last != 32) f_sp_bad++;
                last = cyc;
                f_rises++;
            end
            if (SS_n === 1'b1 && SCLK !== 1'b1) f_idle_bad++;
`ifdef SPI_MNRCH_BUSY_EN
            if (done !== 1'b1 && busy !== 1'b1) f_busy_bad++;
            if (done === 1'b1 && busy !== 1'b0) f_busy_bad++;
`endif
            prev = SCLK;
        end
        snd        = 1'b0;
        f_len      = cyc;
        f_gap      = cyc - last;
        f_ss_end   = SS_n;
        f_sclk_end = SCLK;
    endtask

    initial begin
        int stray;

        // Reset state
        #22;
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp", 32'(resp), 32'h0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
`ifdef SPI_MNRCH_BUSY_EN
        chk("rst_busy", 32'(busy), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Sensor read of WHO_AM_I
        run_frame(16'h8F00, 1'b0);
        chk("rd_ss_fall", 32'(f_ss_start), 32'd0);
        chk("rd_len", 32'(f_len), 32'd520);
        chk("rd_resp", 32'(resp), 32'h006A);
        chk("rd_ss_end", 32'(f_ss_end), 32'd1);
        chk("rd_sclk_end", 32'(f_sclk_end), 32'd1);
        chk("rd_last_rise_gap", 32'(f_gap), 32'd16);
`ifdef SPI_MNRCH_BUSY_EN
        chk("rd_busy", 32'(f_busy_bad), 32'd0);
`endif
        repeat (5) @(negedge clk);
        chk("rd_done_sticky", 32'(done), 32'd1);
        chk("rd_resp_stable", 32'(resp), 32'h006A);

        // Sensor write to INT1_CTRL
        chk("wr_int_before", 32'(int_q), 32'd0);
        run_frame(16'h0D02, 1'b0);
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_ss_n", 32'(f_ss_end), 32'd1);
        @(negedge clk);
        chk("wr_int_after", 32'(int_q), 32'd1);
        chk("wr_resp", 32'(resp), 32'h0000);

        // Loopback with a re-trigger attempt 100 clks in
        loop_en = 1'b1;
        run_frame(16'hA5C3, 1'b1);
        chk("lb_len", 32'(f_len), 32'd520);
        chk("lb_resp", 32'(resp), 32'hA5C3);
        chk("lb_rises", 32'(f_rises), 32'd16);
        chk("lb_spacing", 32'(f_sp_bad), 32'd0);
        chk("lb_sclk_idle", 32'(f_idle_bad), 32'd0);
`ifdef SPI_MNRCH_BUSY_EN
        chk("lb_busy", 32'(f_busy_bad), 32'd0);
`endif
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || SCLK !== 1'b1 || done !== 1'b1) stray++;
        end
        chk("lb_single_frame", 32'(stray), 32'd0);
        loop_en = 1'b0;

        // Reset mid-frame around bit 7
        @(negedge clk);
        cmd = 16'h8F00;
        snd = 1'b1;
        @(negedge clk);
        snd = 1'b0;
        repeat (242) @(negedge clk);
        chk("mid_ss_low", 32'(SS_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
        chk("mid_rst_sclk", 32'(SCLK), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_resp", 32'(resp), 32'h0);
`ifdef SPI_MNRCH_BUSY_EN
        chk("mid_rst_busy", 32'(busy), 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_ss_n", 32'(SS_n), 32'd1);

        run_frame(16'h8F00, 1'b0);
        chk("re_len", 32'(f_len), 32'd520);
        chk("re_resp", 32'(resp), 32'h006A);
        chk("re_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
